disp_scroll_ctrl: RTL and testbench

Sequencer that feeds the four 8-bit segment inputs of the 4-digit multiplexed seven-segment display driver.
- Host writes a message of up to DEPTH segment patterns into an internal buffer.
- The controller scrolls a 4-digit window across the message at a programmable rate, or shows it statically.
- Sits between the host/bus logic and the display multiplexer. Segment patterns are active-low, and 0xFF means blank.

---
 rtl/disp_scroll_ctrl.sv | 120 ++++++++++++
 tb/tb_disp_scroll_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scroll_ctrl.sv
// Scroll/static sequencer feeding the four segment inputs of a 4-digit display mux.
// A 4-digit window slides over a host-written message buffer of active-low patterns.
module disp_scroll_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  output logic          busy,
  output logic          wrap,
  output logic [7:0]    in3,
  output logic [7:0]    in2,
  output logic [7:0]    in1,
  output logic [7:0]    in0
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   MIN_RUN = (AW+1)'(4);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [AW:0]     r_len, w_len_next;
  logic [AW-1:0]   r_ptr, w_ptr_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_wrap, w_wrap_next;
  logic [7:0]      r_buf [DEPTH];
  logic [3:0][7:0] w_seg;
  logic [3:0][7:0] r_seg;
  logic [AW:0]     w_len_clamp;

  assign w_len_clamp = (len > DEPTH_L) ? DEPTH_L : len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_wrap  <= w_wrap_next;
    end
  end

  // stop has priority over start; a simultaneous start does not touch len
  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_wrap_next  = 1'b0;
    if (stop) begin
      w_state_next = S_IDLE;
      w_ptr_next   = '0;
      w_cnt_next   = '0;
    end else if (start) begin
      w_len_next   = w_len_clamp;
      w_ptr_next   = '0;
      w_cnt_next   = '0;
      w_state_next = (w_len_clamp > MIN_RUN) ? S_RUN : S_IDLE;
    end else if (r_state == S_RUN && !pause) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_next = '0;
        if ({1'b0, r_ptr} == r_len - (AW+1)'(1)) begin
          w_ptr_next  = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_ptr_next = r_ptr + AW'(1);
        end
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'hFF;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Digit gi shows entry ptr+gi modulo len; positions beyond a short message stay blank
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_idx;
    assign w_sum     = {1'b0, r_ptr} + (AW+1)'(gi);
    assign w_idx     = (w_sum >= r_len) ? AW'(w_sum - r_len) : AW'(w_sum);
    assign w_seg[gi] = ((AW+1)'(gi) >= r_len) ? 8'hFF : r_buf[w_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_seg <= '1;
    else       r_seg <= w_seg;
  end

  assign in3  = r_seg[0];
  assign in2  = r_seg[1];
  assign in1  = r_seg[2];
  assign in0  = r_seg[3];
  assign busy = (r_state == S_RUN);
  assign wrap = r_wrap;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Directed bench for disp_scroll_ctrl: expected window/busy/wrap per cycle are queued
// when stimulus is applied and compared as the DUT produces each registered output.
module tb_disp_scroll_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TDIV  = 4;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   len;
  logic          start;
  logic          stop;
  logic          pause;
  logic          busy;
  logic          wrap;
  logic [7:0]    in3, in2, in1, in0;

  disp_scroll_ctrl #(.DEPTH(DEPTH), .AW(AW), .TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .stop(stop), .pause(pause), .busy(busy), .wrap(wrap),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] win;
    logic        busy;
    logic        wrap;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] msg [6];

  function automatic logic [31:0] win_at(int p, int l);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[31-8*k -: 8] = (k >= l) ? 8'hFF : msg[(p + k) % l];
    return w;
  endfunction

  task automatic push(string tag, logic [31:0] win, logic b, logic w, int n);
    exp_t e;
    e.tag = tag; e.win = win; e.busy = b; e.wrap = w;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d entries need=1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert ({in3, in2, in1, in0} === e.win) else begin
        bad++;
        $error("FAIL %s window got=%h exp=%h", e.tag, {in3, in2, in1, in0}, e.win);
      end
      total++;
      assert (busy === e.busy) else begin
        bad++;
        $error("FAIL %s busy got=%b exp=%b", e.tag, busy, e.busy);
      end
      total++;
      assert (wrap === e.wrap) else begin
        bad++;
        $error("FAIL %s wrap got=%b exp=%b", e.tag, wrap, e.wrap);
      end
    end
  endtask

  task automatic run_chk(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_out();
    end
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(logic [AW:0] l);
    len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    msg[0] = 8'hC0; msg[1] = 8'hF9; msg[2] = 8'hA4;
    msg[3] = 8'hB0; msg[4] = 8'h99; msg[5] = 8'h92;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0; stop = 1'b0; pause = 1'b0;

    // Asynchronous reset takes effect without a clock edge
    #2 reset = 1'b1;
    #1;
    push("reset_async", 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    check_out();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    push("idle_blank", 32'hFFFF_FFFF, 1'b0, 1'b0, 100);
    run_chk(100);

    for (int i = 0; i < 6; i++) do_write(AW'(i), msg[i]);

    // Scroll len 6: window m visible after edge 4m+1, wrap on edge 24
    pulse_start(5'd6);
    for (int n = 1; n <= 28; n++)
      push("scroll", win_at(((n - 1) / 4) % 6, 6), 1'b1, (n == 24), 1);
    run_chk(28);

    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    push("stop_edge", win_at(1, 6), 1'b0, 1'b0, 1);
    check_out();
    push("stop_idle", win_at(0, 6), 1'b0, 1'b0, 4);
    run_chk(4);

    pulse_start(5'd3);
    push("static_len3", 32'hC0F9_A4FF, 1'b0, 1'b0, 50);
    run_chk(50);

    // Pause after two counts: step lands two edges after resume
    pulse_start(5'd6);
    push("pause_hold", win_at(0, 6), 1'b1, 1'b0, 14);
    push("pause_resume", win_at(1, 6), 1'b1, 1'b0, 1);
    run_chk(2);
    pause = 1'b1;
    run_chk(10);
    pause = 1'b0;
    run_chk(3);

    push("run_ptr1", win_at(1, 6), 1'b1, 1'b0, 3);
    push("run_ptr2", win_at(2, 6), 1'b1, 1'b0, 4);
    run_chk(7);

    // start+stop together at ptr 3: stop wins, len 2 must not be latched
    len = 5'd2; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    push("startstop_edge", win_at(3, 6), 1'b0, 1'b0, 1);
    check_out();
    push("startstop_idle", win_at(0, 6), 1'b0, 1'b0, 5);
    run_chk(5);

    pulse_start(5'd6);
    push("wr_before", win_at(0, 6), 1'b1, 1'b0, 1);
    run_chk(1);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h00;
    @(posedge clk); #1;
    wr_en = 1'b0;
    push("wr_same_edge", win_at(0, 6), 1'b1, 1'b0, 1);
    check_out();
    push("wr_visible", 32'hC000_A4B0, 1'b1, 1'b0, 1);
    run_chk(1);

    #2 reset = 1'b1;
    #1;
    push("reset_midrun", 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    check_out();
    #1 reset = 1'b0;

    pulse_start(5'd6);
    push("buf_blanked", 32'hFFFF_FFFF, 1'b1, 1'b0, 3);
    run_chk(3);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
